// File: rtl/serial_wide_adder_ctrl_if.sv
// serial_wide_adder_ctrl_if
// Groups the request/response signals between a requesting datapath and the
// serial wide adder controller.
//   start      request, sampled only while the controller is idle
//   a, b, cin  operands and carry-in, captured on the accepting edge
//   busy       high while slices are being computed
//   done       one-cycle pulse, result valid
//   sum        registered result, holds the last completed result
//   cout       carry out of the top bit, registered with sum
//   ovf        signed overflow flag, registered with sum
// Modports: master = requester, slave = controller.
interface serial_wide_adder_ctrl_if #(
  parameter int SIZE   = 4,
  parameter int NSLICE = 4
);
  localparam int WIDTH = SIZE * NSLICE;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_wide_adder_ctrl.sv
// serial_wide_adder_ctrl
// Adds two WIDTH-bit operands by reusing one SIZE-bit ripple adder slice over
// NSLICE cycles, least-significant slice first, with the carry kept in a flop
// between slices. Trades latency for adder area.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   slave side of serial_wide_adder_ctrl_if (start/a/b/cin in,
//         busy/done/sum/cout/ovf out)
// A request accepted at edge T produces done (and the new sum) in the cycle
// after edge T+NSLICE; the next request can be accepted at edge T+NSLICE+2.
module serial_wide_adder_ctrl #(
  parameter int SIZE   = 4,
  parameter int NSLICE = 4
) (
  input logic                    clk,
  input logic                    rst,
  serial_wide_adder_ctrl_if.slave bus
);

  localparam int WIDTH = SIZE * NSLICE;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   sumReg;
  logic               coutReg;
  logic               ovfReg;
  logic               busyReg;
  logic               doneReg;

  logic [SIZE-1:0]    sliceA;
  logic [SIZE-1:0]    sliceB;
  logic [SIZE:0]      sliceSum;
  logic [WIDTH-1:0]   workNext;
  logic               lastSlice;
  logic               ovfNext;

  // The shared slice: pick the current operand slices, add them with the held
  // carry, and merge the slice result into a copy of the working sum so the
  // final slice can be loaded straight into the result register.
  always_comb begin
    sliceA    = opa[idx*SIZE +: SIZE];
    sliceB    = opb[idx*SIZE +: SIZE];
    sliceSum  = {1'b0, sliceA} + {1'b0, sliceB} + {{SIZE{1'b0}}, carry};
    workNext  = work;
    workNext[idx*SIZE +: SIZE] = sliceSum[SIZE-1:0];
    lastSlice = (idx == IDX_W'(NSLICE - 1));
    ovfNext   = (opa[WIDTH-1] == opb[WIDTH-1]) && (workNext[WIDTH-1] != opa[WIDTH-1]);
  end

  // Sequencer: capture on accept, one slice per RUN cycle, then a single DONE
  // cycle. busy/done are registered alongside the state so the requester sees
  // no combinational path from any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      work    <= '0;
      sumReg  <= '0;
      coutReg <= 1'b0;
      ovfReg  <= 1'b0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa     <= bus.a;
            opb     <= bus.b;
            carry   <= bus.cin;
            idx     <= '0;
            busyReg <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          work  <= workNext;
          carry <= sliceSum[SIZE];
          if (lastSlice) begin
            // Result registers only move here, so sum stays stable all through RUN.
            idx     <= '0;
            sumReg  <= workNext;
            coutReg <= sliceSum[SIZE];
            ovfReg  <= ovfNext;
            busyReg <= 1'b0;
            doneReg <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          doneReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busyReg <= 1'b0;
          doneReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.sum  = sumReg;
  assign bus.cout = coutReg;
  assign bus.ovf  = ovfReg;

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// tb_serial_wide_adder_ctrl
// Self-checking bench for serial_wide_adder_ctrl with SIZE=4, NSLICE=4.
// Inputs are driven on the falling edge and outputs sampled there too; a
// monitor pops expected results from a queue whenever done pulses.
module tb_serial_wide_adder_ctrl;

  localparam int SIZE   = 4;
  localparam int NSLICE = 4;
  localparam int WIDTH  = SIZE * NSLICE;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] expSum;
    logic             expCout;
    logic             expOvf;
  } vec_t;

  logic clk;
  logic rst;

  int   total = 0;
  int   bad = 0;
  int   doneCount = 0;
  res_t expQ[$];
  logic [WIDTH-1:0] lastSum = '0;

  serial_wide_adder_ctrl_if #(.SIZE(SIZE), .NSLICE(NSLICE)) bus ();

  serial_wide_adder_ctrl #(.SIZE(SIZE), .NSLICE(NSLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck DUT still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      res_t e;
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sum", 32'(bus.sum), 32'(e.sum));
        checkOutput("cout", 32'(bus.cout), 32'(e.cout));
        checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  // Drives one start pulse, records the expected result, then scrambles the
  // operands so any late sampling of a/b/cin shows up as a wrong sum.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic [WIDTH-1:0] eSum,
                               input logic eCout, input logic eOvf);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    expQ.push_back('{sum: eSum, cout: eCout, ovf: eOvf});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  // Waits (bounded) for done; returns the number of falling edges seen
  // after the accepting edge and how many of them had busy high.
  task automatic waitDone(output int n, output int busyCnt, input logic checkHold);
    n = 0;
    busyCnt = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) busyCnt++;
      if (checkHold) checkOutput("sumHold", 32'(bus.sum), 32'(lastSum));
      @(negedge clk);
      n++;
    end
  endtask

  task automatic runOp(input vec_t v);
    int n;
    int busyCnt;
    applyStimulus(v.a, v.b, v.cin, v.expSum, v.expCout, v.expOvf);
    waitDone(n, busyCnt, 1'b1);
    checkOutput("latency", 32'(n), 32'(NSLICE));
    checkOutput("busyCycles", 32'(busyCnt), 32'(NSLICE));
    checkOutput("busyAtDone", 32'(bus.busy), 32'd0);
    lastSum = v.expSum;
    @(negedge clk);
    checkOutput("donePulseWidth", 32'(bus.done), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int busyCnt;
    int doneAt[$];
    int doneBefore;

    vecs[0] = '{16'h0033, 16'h00CC, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[1] = '{16'h0007, 16'h0000, 1'b1, 16'h0008, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[3] = '{16'h3333, 16'hCCCC, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 32'(bus.busy), 32'd0);
    checkOutput("resetDone", 32'(bus.done), 32'd0);
    checkOutput("resetSum", 32'(bus.sum), 32'd0);
    checkOutput("resetCout", 32'(bus.cout), 32'd0);
    checkOutput("resetOvf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 8; i++) runOp(vecs[i]);

    $display("[TB] start pulsed during RUN is ignored");
    doneBefore = doneCount;
    applyStimulus(16'h1000, 16'h0200, 1'b0, 16'h1200, 1'b0, 1'b0);
    @(negedge clk);
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(n, busyCnt, 1'b1);
    checkOutput("ignoredStartLatency", 32'(n + 2), 32'(NSLICE));
    lastSum = 16'h1200;
    repeat (8) @(negedge clk);
    checkOutput("ignoredStartDones", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("ignoredStartIdle", 32'(bus.busy), 32'd0);

    $display("[TB] start held high");
    doneBefore = doneCount;
    @(negedge clk);
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) expQ.push_back('{sum: 16'h0003, cout: 1'b0, ovf: 1'b0});
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneAt.push_back(c);
      if (c == 16) bus.start = 1'b0;
    end
    checkOutput("heldStartDones", 32'(doneCount - doneBefore), 32'd3);
    if (doneAt.size() == 3) begin
      checkOutput("heldStartFirst", 32'(doneAt[0]), 32'(NSLICE));
      checkOutput("heldStartGap1", 32'(doneAt[1] - doneAt[0]), 32'(NSLICE + 2));
      checkOutput("heldStartGap2", 32'(doneAt[2] - doneAt[1]), 32'(NSLICE + 2));
    end else begin
      checkOutput("heldStartDoneList", 32'(doneAt.size()), 32'd3);
    end
    lastSum = 16'h0003;

    $display("[TB] reset mid-operation");
    doneBefore = doneCount;
    @(negedge clk);
    bus.a     = 16'hABCD;
    bus.b     = 16'h0001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
    checkOutput("midResetDone", 32'(bus.done), 32'd0);
    checkOutput("midResetSum", 32'(bus.sum), 32'd0);
    checkOutput("midResetCout", 32'(bus.cout), 32'd0);
    checkOutput("midResetOvf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("midResetNoDone", 32'(doneCount - doneBefore), 32'd0);
    lastSum = '0;
    runOp(vecs[6]);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
